battle_turn_scheduler: RTL and testbench

Sequences the combat accuracy engine through alternating player and enemy turns once the player and enemy sprites collide. It accepts the player's weapon selection via a valid/ready handshake and generates the enemy's selection from an internal LFSR. It substitutes bare hands for exhausted weapons, drives `player_turn`, `attacker_turn`, `player_choice` and `enemy_choice` into the engine, and stops the battle when the engine reports a winner. It sits between the input/collision logic and the engine.

---
 rtl/battle_turn_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_battle_turn_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/battle_turn_scheduler.sv
// Battle turn scheduler: alternates player and enemy strike phases for the
// combat accuracy engine once the sprites collide, until a winner is reported.
// Ports: clk, rst_n (async active-low); collision_detected; choice_valid/choice
// /choice_ready handshake; player/enemy remaining sword and bat counts;
// player_win/enemy_win; player_turn, attacker_turn, player_choice,
// enemy_choice to the engine; battle_active, battle_over, turn_count status.
module battle_turn_scheduler #(
    parameter int STRIKE_CYCLES  = 4,
    parameter int SELECT_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       collision_detected,
    input  logic       choice_valid,
    input  logic [1:0] choice,
    output logic       choice_ready,
    input  logic [4:0] player_remained_sword,
    input  logic [4:0] player_remained_baseballbat,
    input  logic [4:0] enemy_remained_sword,
    input  logic [4:0] enemy_remained_baseballbat,
    input  logic       player_win,
    input  logic       enemy_win,
    output logic       player_turn,
    output logic       attacker_turn,
    output logic [1:0] player_choice,
    output logic [1:0] enemy_choice,
    output logic       battle_active,
    output logic       battle_over,
    output logic [7:0] turn_count
);

    typedef enum logic [2:0] {
        IDLE,
        P_SELECT,
        P_STRIKE,
        P_CHECK,
        E_SELECT,
        E_STRIKE,
        E_CHECK,
        DONE
    } state_t;

    localparam logic [7:0] SEL_LAST = 8'(SELECT_TIMEOUT - 1);
    localparam logic [3:0] STR_LAST = 4'(STRIKE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] sel_cnt_q, sel_cnt_d;
    logic [3:0] strike_cnt_q, strike_cnt_d;
    // Remembers a collision loss seen during a strike so the strike can
    // finish its full length before the battle is abandoned.
    logic       abort_q, abort_d;
    logic [1:0] p_choice_q, p_choice_d;
    logic [1:0] e_choice_q, e_choice_d;
    logic [7:0] turn_cnt_q, turn_cnt_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic       win;

    // Exhausted or reserved weapons fall back to bare hands.
    function automatic logic [1:0] sanitize(
        input logic [1:0] c,
        input logic [4:0] sw,
        input logic [4:0] bb
    );
        logic [1:0] r;
        r = 2'b00;
        if (c == 2'b01 && sw != 5'd0) begin
            r = 2'b01;
        end
        if (c == 2'b10 && bb != 5'd0) begin
            r = 2'b10;
        end
        return r;
    endfunction

    // x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign win    = player_win | enemy_win;

    always_comb begin
        state_d      = state_q;
        sel_cnt_d    = '0;
        strike_cnt_d = '0;
        abort_d      = abort_q;
        p_choice_d   = p_choice_q;
        e_choice_d   = e_choice_q;
        turn_cnt_d   = turn_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (collision_detected) begin
                    state_d    = P_SELECT;
                    turn_cnt_d = '0;
                end
            end
            P_SELECT: begin
                sel_cnt_d = sel_cnt_q + 8'd1;
                if (!collision_detected) begin
                    state_d = IDLE;
                end else if (choice_valid) begin
                    p_choice_d = sanitize(choice, player_remained_sword,
                                          player_remained_baseballbat);
                    abort_d    = 1'b0;
                    state_d    = P_STRIKE;
                end else if (sel_cnt_q == SEL_LAST) begin
                    p_choice_d = 2'b00;
                    abort_d    = 1'b0;
                    state_d    = P_STRIKE;
                end
            end
            P_STRIKE, E_STRIKE: begin
                strike_cnt_d = strike_cnt_q + 4'd1;
                abort_d      = abort_q | ~collision_detected;
                if (strike_cnt_q == STR_LAST) begin
                    if (abort_q || !collision_detected) begin
                        state_d = IDLE;
                    end else if (state_q == P_STRIKE) begin
                        state_d = P_CHECK;
                    end else begin
                        state_d = E_CHECK;
                    end
                end
            end
            P_CHECK: begin
                if (win) begin
                    state_d = DONE;
                end else if (!collision_detected) begin
                    state_d = IDLE;
                end else begin
                    state_d = E_SELECT;
                end
            end
            E_SELECT: begin
                if (!collision_detected) begin
                    state_d = IDLE;
                end else begin
                    e_choice_d = sanitize(lfsr_q[1:0], enemy_remained_sword,
                                          enemy_remained_baseballbat);
                    abort_d    = 1'b0;
                    state_d    = E_STRIKE;
                end
            end
            E_CHECK: begin
                if (win) begin
                    state_d = DONE;
                end else if (!collision_detected) begin
                    state_d = IDLE;
                end else begin
                    if (turn_cnt_q != 8'hFF) begin
                        turn_cnt_d = turn_cnt_q + 8'd1;
                    end
                    state_d = P_SELECT;
                end
            end
            DONE: begin
                if (!collision_detected) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Clearing on the way into IDLE keeps the selects at 00 for the
        // whole time the FSM sits there.
        if (state_d == IDLE) begin
            p_choice_d = 2'b00;
            e_choice_d = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_cnt_q    <= '0;
            strike_cnt_q <= '0;
            abort_q      <= 1'b0;
            p_choice_q   <= 2'b00;
            e_choice_q   <= 2'b00;
            turn_cnt_q   <= '0;
            lfsr_q       <= 8'hA5;
        end else begin
            state_q      <= state_d;
            sel_cnt_q    <= sel_cnt_d;
            strike_cnt_q <= strike_cnt_d;
            abort_q      <= abort_d;
            p_choice_q   <= p_choice_d;
            e_choice_q   <= e_choice_d;
            turn_cnt_q   <= turn_cnt_d;
            lfsr_q       <= lfsr_d;
        end
    end

    assign choice_ready  = (state_q == P_SELECT);
    assign player_turn   = (state_q == P_STRIKE);
    assign attacker_turn = (state_q == P_STRIKE) || (state_q == E_STRIKE);
    assign battle_active = (state_q != IDLE) && (state_q != DONE);
    assign battle_over   = (state_q == DONE);
    assign player_choice = p_choice_q;
    assign enemy_choice  = e_choice_q;
    assign turn_count    = turn_cnt_q;

endmodule

// File: tb/tb_battle_turn_scheduler.sv
// Scoreboard bench for battle_turn_scheduler: randomized battles, expected
// strikes queued by the driver and checked by an independent strike monitor.
module tb_battle_turn_scheduler;

    localparam int STRIKE = 4;
    localparam int SEL_TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       collision_detected;
    logic       choice_valid;
    logic [1:0] choice;
    logic       choice_ready;
    logic [4:0] player_remained_sword;
    logic [4:0] player_remained_baseballbat;
    logic [4:0] enemy_remained_sword;
    logic [4:0] enemy_remained_baseballbat;
    logic       player_win;
    logic       enemy_win;
    logic       player_turn;
    logic       attacker_turn;
    logic [1:0] player_choice;
    logic [1:0] enemy_choice;
    logic       battle_active;
    logic       battle_over;
    logic [7:0] turn_count;

    battle_turn_scheduler #(
        .STRIKE_CYCLES (STRIKE),
        .SELECT_TIMEOUT(SEL_TO)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .collision_detected         (collision_detected),
        .choice_valid               (choice_valid),
        .choice                     (choice),
        .choice_ready               (choice_ready),
        .player_remained_sword      (player_remained_sword),
        .player_remained_baseballbat(player_remained_baseballbat),
        .enemy_remained_sword       (enemy_remained_sword),
        .enemy_remained_baseballbat (enemy_remained_baseballbat),
        .player_win                 (player_win),
        .enemy_win                  (enemy_win),
        .player_turn                (player_turn),
        .attacker_turn              (attacker_turn),
        .player_choice              (player_choice),
        .enemy_choice               (enemy_choice),
        .battle_active              (battle_active),
        .battle_over                (battle_over),
        .turn_count                 (turn_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_p;
        logic [1:0] pch;
        logic [4:0] esw;
        logic [4:0] ebb;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;

    // Reference LFSR history: hist[n] is the register after n active edges.
    logic [7:0] hist[$];
    logic [7:0] ref_l;
    int         cyc;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        logic fb;
        fb = ^(v & 8'hB8);
        return {v[6:0], fb};
    endfunction

    function automatic logic [1:0] san(input logic [1:0] c,
                                       input logic [4:0] sw,
                                       input logic [4:0] bb);
        if (c == 2'd1) return (sw == 5'd0) ? 2'd0 : 2'd1;
        if (c == 2'd2) return (bb == 5'd0) ? 2'd0 : 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [4:0] rnd_cnt();
        if ($urandom_range(0, 2) == 0) return 5'd0;
        return 5'($urandom_range(1, 31));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            ref_l = lfsr_step(ref_l);
            hist.push_back(ref_l);
            cyc++;
        end
    end

    // Strike monitor: measures each attacker_turn pulse and scores it.
    bit         in_strike = 0;
    int         s_len;
    int         s_cyc;
    bit         s_pt;
    logic [1:0] s_ch;
    exp_t       m_it;
    logic [1:0] m_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_strike = 0;
        end else if (attacker_turn && !in_strike) begin
            in_strike = 1;
            s_len     = 1;
            s_pt      = player_turn;
            s_ch      = player_turn ? player_choice : enemy_choice;
            s_cyc     = cyc;
        end else if (attacker_turn) begin
            s_len++;
        end else if (in_strike) begin
            in_strike = 0;
            if (exp_q.size() == 0) begin
                chk("unexpected_strike", 32'(exp_q.size()), 32'd1);
            end else begin
                m_it = exp_q.pop_front();
                chk("strike_owner", 32'(s_pt), 32'(m_it.is_p));
                if (m_it.is_p) m_exp = m_it.pch;
                else m_exp = san(hist[s_cyc-1][1:0], m_it.esw, m_it.ebb);
                chk(s_pt ? "player_choice" : "enemy_choice",
                    32'(s_ch), 32'(m_exp));
                chk("strike_len", 32'(s_len), 32'(STRIKE));
            end
        end
    end

    function automatic logic [31:0] outs_vec();
        return 32'({player_turn, attacker_turn, choice_ready, battle_active,
                    battle_over, player_choice, enemy_choice});
    endfunction

    task automatic end_done(input int r);
        int k;
        k = 0;
        while (!battle_over && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("battle_over", 32'(battle_over), 32'd1);
        chk("done_turn_count", 32'(turn_count), 32'(r));
        chk("done_active", 32'({battle_active, attacker_turn}), 32'd0);
        collision_detected = 1'b0;
        @(negedge clk);
        chk("idle_outs", outs_vec(), 32'd0);
        player_win = 1'b0;
        enemy_win  = 1'b0;
    endtask

    // mode 0: win during the last player strike; 1: win during the last
    // enemy strike; 2: collision lost during the last enemy strike.
    task automatic battle(input int nr, input int mode, input bit ez,
                          input int fch, input int fd,
                          input int fsw, input int fbb);
        int   d, d_prev, ch, k, t_prev;
        bit   last;
        exp_t it;
        d_prev = 0;
        t_prev = 0;
        collision_detected = 1'b1;
        for (int r = 0; r < nr; r++) begin
            if (r == 0) begin
                @(negedge clk);
            end else begin
                k = 0;
                while (!choice_ready && k < 40) begin
                    @(negedge clk);
                    k++;
                end
            end
            chk("ready", 32'(choice_ready), 32'd1);
            chk("turn_count", 32'(turn_count), 32'(r));
            if (r > 0) begin
                chk("round_len", 32'(cyc - t_prev),
                    32'(((d_prev < SEL_TO) ? d_prev + 1 : SEL_TO) + 2 * STRIKE + 3));
            end
            t_prev = cyc;
            player_remained_sword       = (r == 0 && fsw >= 0) ? 5'(fsw) : rnd_cnt();
            player_remained_baseballbat = (r == 0 && fbb >= 0) ? 5'(fbb) : rnd_cnt();
            enemy_remained_sword        = ez ? 5'd0 : rnd_cnt();
            enemy_remained_baseballbat  = ez ? 5'd0 : rnd_cnt();
            ch = (r == 0 && fch >= 0) ? fch : int'($urandom_range(0, 3));
            if (r == 0 && fd >= 0) d = fd;
            else if ($urandom_range(0, 4) == 0) d = SEL_TO + int'($urandom_range(0, 3));
            else d = int'($urandom_range(0, 5));
            d_prev = d;
            it.is_p = 1;
            it.pch  = (d < SEL_TO) ? san(2'(ch), player_remained_sword,
                                         player_remained_baseballbat) : 2'd0;
            it.esw  = 5'd0;
            it.ebb  = 5'd0;
            exp_q.push_back(it);
            k = 0;
            while (choice_ready && k < 40) begin
                choice_valid = (d < SEL_TO) && (k >= d);
                choice       = choice_valid ? 2'(ch) : 2'($urandom);
                @(negedge clk);
                k++;
            end
            choice_valid = 1'b0;
            last = (r == nr - 1);
            if (last && mode == 0) begin
                if ($urandom_range(0, 1) == 0) enemy_win = 1'b1;
                else player_win = 1'b1;
                end_done(r);
                return;
            end
            it.is_p = 0;
            it.pch  = 2'd0;
            it.esw  = enemy_remained_sword;
            it.ebb  = enemy_remained_baseballbat;
            exp_q.push_back(it);
            if (last) begin
                k = 0;
                while (!(attacker_turn && !player_turn) && k < 30) begin
                    @(negedge clk);
                    k++;
                end
                chk("e_strike_start", 32'(attacker_turn && !player_turn), 32'd1);
                if (mode == 1) begin
                    enemy_win = 1'b1;
                    end_done(r);
                end else begin
                    collision_detected = 1'b0;
                    k = 0;
                    while (attacker_turn && k < 30) begin
                        @(negedge clk);
                        k++;
                    end
                    chk("abort_turn_count", 32'(turn_count), 32'(r));
                    chk("abort_idle_outs", outs_vec(), 32'd0);
                end
            end
        end
    endtask

    initial begin
        rst_n                       = 1'b0;
        collision_detected          = 1'b0;
        choice_valid                = 1'b0;
        choice                      = 2'd0;
        player_remained_sword       = 5'd5;
        player_remained_baseballbat = 5'd5;
        enemy_remained_sword        = 5'd5;
        enemy_remained_baseballbat  = 5'd5;
        player_win                  = 1'b0;
        enemy_win                   = 1'b0;
        ref_l = 8'hA5;
        cyc   = 0;
        hist.push_back(8'hA5);
        repeat (3) @(negedge clk);
        chk("reset_outs", outs_vec(), 32'd0);
        chk("reset_turn_count", 32'(turn_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        battle(3, 1, 0, 1, 0, 5, 5);
        battle(2, 0, 0, 1, SEL_TO, 5, 5);
        battle(2, 2, 0, 2, 1, 5, 0);
        battle(2, 0, 0, 3, 0, 5, 5);
        battle(50, 2, 1, -1, -1, -1, -1);
        repeat (6) begin
            battle(int'($urandom_range(2, 8)), int'($urandom_range(0, 2)), 0,
                   -1, -1, -1, -1);
        end

        // Asynchronous reset in the middle of a player strike.
        collision_detected = 1'b1;
        @(negedge clk);
        chk("ready_before_reset", 32'(choice_ready), 32'd1);
        choice       = 2'd1;
        choice_valid = 1'b1;
        @(negedge clk);
        choice_valid = 1'b0;
        chk("strike_before_reset", 32'(attacker_turn), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outs", outs_vec(), 32'd0);
        chk("async_reset_turn_count", 32'(turn_count), 32'd0);
        collision_detected = 1'b0;
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
